// File: rtl/lfsr_pkg.sv
// Shared definitions for the multi-channel LFSR bank: XNOR tap table,
// draw FSM states and sizing constants.
package lfsr_pkg;

  localparam int MAX_BITS = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    PRESENT = 2'd2
  } fsm_state_t;

  function automatic logic [MAX_BITS-1:0] tap_bit(input int n);
    return 32'd1 << (n - 1);
  endfunction

  // Maximal-length XNOR taps, 1-indexed bit positions per register width.
  function automatic logic [MAX_BITS-1:0] tap_mask(input int width);
    logic [MAX_BITS-1:0] m;
    m = '0;
    case (width)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One LFSR channel: state and seed registers, step/load, wrap pulse and
// sticky all-ones lock-up recovery flag.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS  = 11,
  parameter logic [NUM_BITS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic                load_en,
  input  logic [NUM_BITS-1:0] load_data,
  output logic [NUM_BITS-1:0] step_val,
  output logic                wrap,
  output logic                lockup
);

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

  logic [NUM_BITS-1:0] state_q, state_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic                wrap_q, wrap_d;
  logic                lockup_q, lockup_d;
  logic                fb;
  logic                all_ones;

  // All-ones is the XNOR dead state, so it is forced to zero instead of shifted.
  assign fb       = ~(^(state_q & TAPS));
  assign all_ones = &state_q;
  assign step_val = all_ones ? '0 : {state_q[NUM_BITS-2:0], fb};

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
    if (load_en) begin
      state_d = load_data;
      seed_d  = load_data;
    end else if (step_en) begin
      state_d = step_val;
      wrap_d  = (step_val == seed_q);
      if (all_ones) lockup_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RESET_VAL;
      seed_q   <= RESET_VAL;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign wrap   = wrap_q;
  assign lockup = lockup_q;

endmodule

// File: rtl/lfsr_bank.sv
// Multi-channel LFSR random source: draw FSM, channel mux and output
// register in front of NUM_CH independent lfsr_core channels.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter  int          NUM_BITS   = 11,
  parameter  int          NUM_CH     = 4,
  parameter  int unsigned RESET_SEED = 0,
  localparam int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Seed_DV,
  input  logic [CH_W-1:0]     i_Seed_Ch,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic                i_Req_Valid,
  input  logic [CH_W-1:0]     i_Req_Ch,
  output logic                o_Req_Ready,
  output logic                o_Rand_Valid,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  input  logic                i_Rand_Ready,
  output logic [NUM_CH-1:0]   o_Wrap,
  output logic [NUM_CH-1:0]   o_Lockup
);

  fsm_state_t          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                ch_valid_q, ch_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] data_q, data_d;

  logic                step_go;
  logic                seed_hit;
  logic                req_in_range;
  logic [NUM_BITS-1:0] sel_step;
  logic [NUM_CH-1:0]   step_vec;
  logic [NUM_CH-1:0]   load_vec;
  logic [NUM_CH-1:0]   wrap_vec;
  logic [NUM_CH-1:0]   lockup_vec;
  logic [NUM_BITS-1:0] step_val_arr [NUM_CH];

  assign req_in_range = (int'(i_Req_Ch) < NUM_CH);
  assign seed_hit     = i_Seed_DV && ch_valid_q && (i_Seed_Ch == ch_q);

  always_comb begin
    step_vec = '0;
    load_vec = '0;
    sel_step = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      step_vec[k] = step_go && ch_valid_q && (int'(ch_q) == k);
      load_vec[k] = i_Seed_DV && (int'(i_Seed_Ch) == k);
      if (ch_valid_q && (int'(ch_q) == k)) sel_step = step_val_arr[k];
    end
  end

  // A seed landing on the channel being drawn restarts the step count.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    ch_valid_d = ch_valid_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    step_go    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Req_Valid) begin
          state_d    = STEP;
          ch_d       = i_Req_Ch;
          ch_valid_d = req_in_range;
          cnt_d      = '0;
        end
      end
      STEP: begin
        if (seed_hit) begin
          cnt_d = '0;
        end else begin
          step_go = 1'b1;
          if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
            state_d = PRESENT;
            data_d  = ch_valid_q ? sel_step : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (i_Rand_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ch_valid_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ch_valid_q <= ch_valid_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    lfsr_core #(
      .NUM_BITS  (NUM_BITS),
      .RESET_VAL (NUM_BITS'(RESET_SEED ^ 32'(k)))
    ) u_core (
      .clk       (i_Clk),
      .rst       (i_Rst),
      .step_en   (step_vec[k]),
      .load_en   (load_vec[k]),
      .load_data (i_Seed_Data),
      .step_val  (step_val_arr[k]),
      .wrap      (wrap_vec[k]),
      .lockup    (lockup_vec[k])
    );
  end

  assign o_Req_Ready  = (state_q == IDLE);
  assign o_Rand_Valid = (state_q == PRESENT);
  assign o_Rand_Data  = data_q;
  assign o_Wrap       = wrap_vec;
  assign o_Lockup     = lockup_vec;

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed bench for lfsr_bank with a 4-bit, 3-channel configuration;
// expected words are hand-stepped XNOR sequences (taps 4,3).
module tb_lfsr_bank;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Seed_DV = 1'b0;
  logic [1:0] i_Seed_Ch = '0;
  logic [3:0] i_Seed_Data = '0;
  logic       i_Req_Valid = 1'b0;
  logic [1:0] i_Req_Ch = '0;
  logic       o_Req_Ready;
  logic       o_Rand_Valid;
  logic [3:0] o_Rand_Data;
  logic       i_Rand_Ready = 1'b0;
  logic [2:0] o_Wrap;
  logic [2:0] o_Lockup;

  int checkCount = 0;
  int errorCount = 0;
  int wrap0Count = 0;
  int wrap1Count = 0;

  always #5 i_Clk = ~i_Clk;

  lfsr_bank #(
    .NUM_BITS   (4),
    .NUM_CH     (3),
    .RESET_SEED (0)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Seed_DV    (i_Seed_DV),
    .i_Seed_Ch    (i_Seed_Ch),
    .i_Seed_Data  (i_Seed_Data),
    .i_Req_Valid  (i_Req_Valid),
    .i_Req_Ch     (i_Req_Ch),
    .o_Req_Ready  (o_Req_Ready),
    .o_Rand_Valid (o_Rand_Valid),
    .o_Rand_Data  (o_Rand_Data),
    .i_Rand_Ready (i_Rand_Ready),
    .o_Wrap       (o_Wrap),
    .o_Lockup     (o_Lockup)
  );

  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (o_Wrap[0]) wrap0Count++;
      if (o_Wrap[1]) wrap1Count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full draw, starting and ending on a falling edge with the FSM idle.
  task automatic applyStimulus(input logic [1:0] ch, input logic [3:0] expData,
                               input int expCycles, input int seedAt,
                               input logic [3:0] seedVal, input int hold);
    int cycles;
    checkOutput("req_ready before draw", o_Req_Ready, 1);
    i_Req_Valid = 1'b1;
    i_Req_Ch    = ch;
    @(negedge i_Clk);
    i_Req_Valid = 1'b0;
    cycles = 1;
    while (!o_Rand_Valid && cycles < 40) begin
      if (cycles == seedAt) begin
        i_Seed_DV   = 1'b1;
        i_Seed_Ch   = ch;
        i_Seed_Data = seedVal;
      end
      @(negedge i_Clk);
      i_Seed_DV = 1'b0;
      cycles++;
    end
    checkOutput("draw valid", o_Rand_Valid, 1);
    checkOutput("draw latency", cycles, expCycles);
    checkOutput("draw data", o_Rand_Data, expData);
    for (int i = 0; i < hold; i++) begin
      i_Seed_DV   = 1'b1;
      i_Seed_Ch   = ch;
      i_Seed_Data = 4'h5;
      @(negedge i_Clk);
      i_Seed_DV = 1'b0;
      checkOutput("hold data", o_Rand_Data, expData);
      checkOutput("hold req_ready", o_Req_Ready, 0);
    end
    i_Rand_Ready = 1'b1;
    @(negedge i_Clk);
    i_Rand_Ready = 1'b0;
    checkOutput("valid after handshake", o_Rand_Valid, 0);
  endtask

  initial begin
    $display("[TB] lfsr_bank directed test starting");
    @(negedge i_Clk);
    @(negedge i_Clk);
    checkOutput("reset req_ready", o_Req_Ready, 1);
    checkOutput("reset rand_valid", o_Rand_Valid, 0);
    checkOutput("reset rand_data", o_Rand_Data, 0);
    checkOutput("reset wrap", o_Wrap, 0);
    checkOutput("reset lockup", o_Lockup, 0);
    i_Rst = 1'b0;

    // ch0 from 0: 1,3,7,E | D,B,6,C | 9,2,5,A | 4,8,0,1
    applyStimulus(2'd0, 4'hE, 5, 0, 4'h0, 0);
    applyStimulus(2'd0, 4'hC, 5, 0, 4'h0, 0);
    // ch1 untouched at 1: 3,7,E,D
    applyStimulus(2'd1, 4'hD, 5, 0, 4'h0, 0);
    applyStimulus(2'd0, 4'hA, 5, 0, 4'h0, 0);
    checkOutput("no wrap before draw 4", wrap0Count, 0);
    applyStimulus(2'd0, 4'h1, 5, 0, 4'h0, 0);
    checkOutput("wrap ch0 once", wrap0Count, 1);
    checkOutput("no wrap ch1", wrap1Count, 0);

    // ch1 seeded all-ones: 0,1,3,7 then 7 -> E,D,B,6
    i_Seed_DV = 1'b1; i_Seed_Ch = 2'd1; i_Seed_Data = 4'hF;
    @(negedge i_Clk);
    i_Seed_DV = 1'b0;
    checkOutput("seed no wrap", o_Wrap, 0);
    applyStimulus(2'd1, 4'h7, 5, 0, 4'h0, 0);
    checkOutput("lockup set", o_Lockup, 3'b010);
    applyStimulus(2'd1, 4'h6, 5, 0, 4'h0, 0);
    checkOutput("lockup sticky", o_Lockup, 3'b010);

    // ch0 at 1: 3,7,E,D; reseeded to 5 while held
    applyStimulus(2'd0, 4'hD, 5, 0, 4'h0, 10);
    // ch0 at 5 steps to A, then seeded 0 on step 2: 1,3,7,E
    applyStimulus(2'd0, 4'hE, 7, 2, 4'h0, 0);

    i_Seed_DV = 1'b1; i_Seed_Ch = 2'd3; i_Seed_Data = 4'hF;
    @(negedge i_Clk);
    i_Seed_DV = 1'b0;
    applyStimulus(2'd3, 4'h0, 5, 0, 4'h0, 0);
    applyStimulus(2'd0, 4'hC, 5, 0, 4'h0, 0);
    applyStimulus(2'd2, 4'h8, 5, 0, 4'h0, 0);

    i_Req_Valid = 1'b1; i_Req_Ch = 2'd0;
    @(negedge i_Clk);
    i_Req_Valid = 1'b0;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    #1;
    checkOutput("midreset req_ready", o_Req_Ready, 1);
    checkOutput("midreset rand_valid", o_Rand_Valid, 0);
    checkOutput("midreset rand_data", o_Rand_Data, 0);
    checkOutput("midreset lockup", o_Lockup, 0);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    applyStimulus(2'd0, 4'hE, 5, 0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
